// File: rtl/register_file.sv
// 32-entry MIPS register file: two operand read ports plus one debug read port, one write port, r0 hardwired to zero.
// Latency: reads are combinational; writes commit on the rising clk edge with no bypass. There is no backpressure.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // The === compare keeps an unknown reg_write from being taken as a write in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if ((reg_write === 1'b1) && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  assign read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
  assign dbg_data   = (dbg_addr  == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps followed by random traffic checked against an array model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  dbg_addr;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] dbg_data;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .dbg_addr  (dbg_addr),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: reset clears everything, otherwise one write to a nonzero address.
  task automatic cyc();
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (reg_write === 1'b1 && write_reg != 5'd0) begin
      model[write_reg] = write_data;
    end
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    reset      = rst;
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    drive(1'b1, 1'b0, 5'd0, 32'h0);
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    dbg_addr  = 5'd0;
    cyc();
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);

    // Reset state on every address of every port.
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      dbg_addr  = 5'(i);
      #1;
      chk("reset_rd1", read_data1, 32'h0);
      chk("reset_rd2", read_data2, 32'h0);
      chk("reset_dbg", dbg_data, 32'h0);
    end

    // Basic write to r5; neighbour stays zero.
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    read_reg1 = 5'd5;
    read_reg2 = 5'd6;
    #1;
    chk("wr_r5", read_data1, 32'hDEAD_BEEF);
    chk("r6_zero", read_data2, 32'h0);

    // Same-address reads on both ports.
    read_reg2 = 5'd5;
    #1;
    chk("same_addr", read_data2, read_data1);
    chk("same_addr_val", read_data2, 32'hDEAD_BEEF);

    // Writes to r0 are discarded.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    dbg_addr  = 5'd0;
    #1;
    chk("r0_rd1", read_data1, 32'h0);
    chk("r0_rd2", read_data2, 32'h0);
    chk("r0_dbg", dbg_data, 32'h0);

    // Read-during-write returns the old value until the edge.
    drive(1'b0, 1'b1, 5'd9, 32'h1111_1111);
    cyc();
    drive(1'b0, 1'b1, 5'd9, 32'h2222_2222);
    read_reg1 = 5'd9;
    #1;
    chk("rdw_before", read_data1, 32'h1111_1111);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    chk("rdw_after", read_data1, 32'h2222_2222);

    // Write enable low leaves r3 untouched, high commits it.
    drive(1'b0, 1'b0, 5'd3, 32'h0000_00AA);
    cyc();
    read_reg1 = 5'd3;
    #1;
    chk("we_low", read_data1, 32'h0);
    drive(1'b0, 1'b1, 5'd3, 32'h0000_00AA);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    chk("we_high", read_data1, 32'h0000_00AA);

    // Reset wins over a simultaneous write, and clears prior contents.
    drive(1'b0, 1'b1, 5'd31, 32'h8000_0000);
    cyc();
    dbg_addr = 5'd31;
    #1;
    chk("r31_set", dbg_data, 32'h8000_0000);
    drive(1'b1, 1'b1, 5'd31, 32'h1234_5678);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("reset_wins", dbg_data, 32'h0);
    read_reg1 = 5'd5;
    read_reg2 = 5'd9;
    #1;
    chk("reset_clr_r5", read_data1, 32'h0);
    chk("reset_clr_r9", read_data2, 32'h0);

    // Random traffic: check all ports before each edge, where reads must still show pre-edge contents.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom), $urandom);
      read_reg1 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
      read_reg2 = ($urandom_range(0, 7) == 0) ? read_reg1 : 5'($urandom);
      dbg_addr  = 5'($urandom);
      #1;
      chk("rand_rd1", read_data1, ref_read(read_reg1));
      chk("rand_rd2", read_data2, ref_read(read_reg2));
      chk("rand_dbg", dbg_data, ref_read(dbg_addr));
      cyc();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0);

    // Final sweep of stored state through the debug port.
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("final_dbg", dbg_data, ref_read(5'(i)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the RegDst write-address mux: `write_reg` is driven by that mux output, selecting rt for I-type or rd for R-type.
- Supplies the two source operands to the ALU and store path.
- Writes are committed on the rising clock edge at the end of the instruction cycle.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH = 32 entries.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable from the control unit.
- read_reg1  input  ADDR_WIDTH  rs address.
- read_reg2  input  ADDR_WIDTH  rt address.
- write_reg  input  ADDR_WIDTH  destination address (RegDst mux output).
- write_data  input  DATA_WIDTH  value to write (MemtoReg mux output).
- dbg_addr  input  ADDR_WIDTH  debug/observation read address.
- read_data1  output  DATA_WIDTH  contents of read_reg1.
- read_data2  output  DATA_WIDTH  contents of read_reg2.
- dbg_data  output  DATA_WIDTH  contents of dbg_addr, for testbench and board display.

Behaviour:
- Storage: 32 x DATA_WIDTH flip-flop array, regs[0..31].
- Reset:
  - At a rising clk edge with reset=1, every entry clears to 0.
  - reset overrides reg_write in the same cycle; no write occurs.
  - Reset asserted mid-program discards all prior contents.
  - Reset value of every output is therefore 0 one edge after reset, for any address.
- Write:
  - At a rising clk edge with reset=0 and reg_write=1, regs[write_reg] <= write_data.
  - Exactly one entry changes per edge.
  - With reg_write=0, no entry changes.
- Register 0:
  - Hardwired zero. Writes with write_reg=0 are discarded.
  - Any read of address 0 returns 0 regardless of history.
  - This holds on all three read ports.
- Read latency:
  - Reads are combinational (zero-cycle): read_data1/2 and dbg_data follow their address inputs within the same cycle.
  - There is no clocked output register.
- Read-during-write:
  - No internal bypass. While reg_write=1 targets address A, a read of A returns the OLD value until the rising edge, then the new value.
  - This matches single-cycle semantics: an instruction's write is visible to the next instruction only.
- Same-address reads: read_reg1 = read_reg2 is legal; both ports return identical data.
- X-handling: an X on reg_write or write_reg must not be treated as a write; the implementation gates writes on reg_write === 1 in simulation only.
- Write data is stored exactly as presented: full-width, no sign extension or truncation.

Test Plan:
1. Reset, then sweep read_reg1/read_reg2/dbg_addr over 0..31 -> every read returns 32'h0000_0000.
2. reg_write=1, write_reg=5, write_data=32'hDEAD_BEEF for one edge; read_reg1=5 -> 32'hDEAD_BEEF. read_reg2=6 -> 0.
3. reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF; read all ports at address 0 -> 0 on every port.
4. Read-during-write:
   - Setup: regs[9]=32'h1111_1111; set write_reg=9, write_data=32'h2222_2222, reg_write=1, read_reg1=9.
   - Before edge -> read_data1=32'h1111_1111.
   - After edge -> read_data1=32'h2222_2222.
5. Write regs[3]=32'h0000_00AA with reg_write=0 -> regs[3] unchanged (0). Repeat with reg_write=1 -> 32'h0000_00AA.
6. Write regs[31]=32'h8000_0000; next edge assert reset together with reg_write=1, write_reg=31, write_data=32'h1234_5678 -> regs[31]=0 after the edge (reset wins); dbg_addr=31 -> dbg_data=0.
